activation_buffer_write_arbiter: RTL and testbench

ACTIVATION_BUFFER_WRITE_ARBITER -- requirements
Module: activation_buffer_write_arbiter

---
 rtl/NVP_v1_constants.sv | 11 +
 rtl/activation_write_source_fifo.sv | 54 +++++
 rtl/activation_buffer_write_arbiter.sv | 133 +++++++++++++
 tb/tb_activation_buffer_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/NVP_v1_constants.sv
// Shared activation-buffer constants and the write-arbitration mode type.
package NVP_v1_constants;
  localparam int NUMBER_OF_ACTIVATION_LINE_BUFFERS = 4;
  localparam int ACTIVATION_BUFFER_BANK_COUNT      = 4;
  localparam int ACTIVATION_BANK_BIT_WIDTH         = 16;
  localparam int ACTIVATION_LINE_BUFFER_DEPTH      = 64;
  localparam int ACTIVATION_WRITE_SOURCE_COUNT     = 2;
  localparam int ACTIVATION_WRITE_FIFO_DEPTH       = 4;

  typedef enum logic {ARB_FIXED, ARB_ROUND_ROBIN} arb_mode_t;
endpackage

// File: rtl/activation_write_source_fifo.sv
// Per-source {data, address} queue; ready is registered from next occupancy.
module activation_write_source_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_entry,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic         ready
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;
  logic          do_push, do_pop;

  assign do_push    = push & ready;
  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;
  assign head       = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // ready stays low throughout reset and rises on the first edge after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next != (PW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/activation_buffer_write_arbiter.sv
// Multi-source write arbiter for the activation line buffers: per-source queues,
// one grant per line buffer per cycle, registered write ports.
module activation_buffer_write_arbiter
  import NVP_v1_constants::*;
#(
  parameter int        NUM_SOURCES       = ACTIVATION_WRITE_SOURCE_COUNT,
  parameter int        NUM_LINE_BUFFERS  = NUMBER_OF_ACTIVATION_LINE_BUFFERS,
  parameter int        BANK_COUNT        = ACTIVATION_BUFFER_BANK_COUNT,
  parameter int        BANK_BIT_WIDTH    = ACTIVATION_BANK_BIT_WIDTH,
  parameter int        LINE_BUFFER_DEPTH = ACTIVATION_LINE_BUFFER_DEPTH,
  parameter int        SOURCE_FIFO_DEPTH = ACTIVATION_WRITE_FIFO_DEPTH,
  parameter arb_mode_t ARB_MODE          = ARB_FIXED,
  localparam int       BSW = $clog2(BANK_COUNT),
  localparam int       LAW = $clog2(LINE_BUFFER_DEPTH),
  localparam int       LSW = $clog2(NUM_LINE_BUFFERS),
  localparam int       AW  = BSW + LAW + LSW
)(
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_SOURCES-1:0]                           i_src_valid,
  output logic [NUM_SOURCES-1:0]                           o_src_ready,
  input  logic [NUM_SOURCES-1:0][BANK_BIT_WIDTH-1:0]       i_src_data,
  input  logic [NUM_SOURCES-1:0][AW-1:0]                   i_src_address,
  output logic [NUM_LINE_BUFFERS-1:0]                      o_write_port_enable,
  output logic [NUM_LINE_BUFFERS-1:0][BANK_COUNT-1:0]      o_write_port_wen,
  output logic [NUM_LINE_BUFFERS-1:0][LAW-1:0]             o_write_port_addr,
  output logic [NUM_LINE_BUFFERS-1:0][BANK_BIT_WIDTH-1:0]  o_write_port_data_in,
  output logic [15:0]                                      o_stall_count,
  output logic                                             o_addr_error,
  output logic                                             o_idle
);
  localparam int EW = BANK_BIT_WIDTH + AW;
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [NUM_SOURCES-1:0][EW-1:0]             head;
  logic [NUM_SOURCES-1:0]                     head_valid, in_range, gnt, err_pop, pop;
  logic [NUM_SOURCES-1:0][LSW-1:0]            head_lb;
  logic [NUM_SOURCES-1:0][LAW-1:0]            head_la;
  logic [NUM_SOURCES-1:0][BSW-1:0]            head_bank;
  logic [NUM_SOURCES-1:0][BANK_BIT_WIDTH-1:0] head_data;
  logic [NUM_SOURCES-1:0][NUM_LINE_BUFFERS-1:0] req;

  logic [NUM_LINE_BUFFERS-1:0]                      found;
  logic [NUM_LINE_BUFFERS-1:0][SW-1:0]              winner, rr_ptr;
  logic [NUM_LINE_BUFFERS-1:0][BANK_COUNT-1:0]      nxt_wen;
  logic [NUM_LINE_BUFFERS-1:0][LAW-1:0]             nxt_addr;
  logic [NUM_LINE_BUFFERS-1:0][BANK_BIT_WIDTH-1:0]  nxt_data;
  logic                                             stall;
  int                                               idx;

  genvar s, l;
  generate
    for (s = 0; s < NUM_SOURCES; s++) begin : g_src
      activation_write_source_fifo #(
        .DEPTH (SOURCE_FIFO_DEPTH),
        .W     (EW)
      ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (i_src_valid[s]),
        .push_entry ({i_src_data[s], i_src_address[s]}),
        .pop        (pop[s]),
        .head       (head[s]),
        .head_valid (head_valid[s]),
        .ready      (o_src_ready[s])
      );

      assign head_bank[s] = head[s][BSW-1:0];
      assign head_la[s]   = head[s][BSW+LAW-1:BSW];
      assign head_lb[s]   = head[s][AW-1:BSW+LAW];
      assign head_data[s] = head[s][EW-1:AW];
      // widened compare keeps the check meaningful for non-power-of-two buffer counts
      assign in_range[s]  = (32'(head_lb[s]) < NUM_LINE_BUFFERS);
      assign err_pop[s]   = head_valid[s] & ~in_range[s];
      assign pop[s]       = gnt[s] | err_pop[s];

      for (l = 0; l < NUM_LINE_BUFFERS; l++) begin : g_req
        assign req[s][l] = head_valid[s] & in_range[s] & (32'(head_lb[s]) == l);
      end
    end
  endgenerate

  always_comb begin
    found    = '0;
    winner   = '0;
    gnt      = '0;
    nxt_wen  = '0;
    nxt_addr = '0;
    nxt_data = '0;
    idx      = 0;
    for (int lb = 0; lb < NUM_LINE_BUFFERS; lb++) begin
      for (int k = 0; k < NUM_SOURCES; k++) begin
        idx = (ARB_MODE == ARB_ROUND_ROBIN) ? (int'(rr_ptr[lb]) + k) % NUM_SOURCES : k;
        if (!found[lb] && req[idx][lb]) begin
          found[lb]  = 1'b1;
          winner[lb] = SW'(idx);
          gnt[idx]   = 1'b1;
        end
      end
      if (found[lb]) begin
        nxt_wen[lb][head_bank[winner[lb]]] = 1'b1;
        nxt_addr[lb] = head_la[winner[lb]];
        nxt_data[lb] = head_data[winner[lb]];
      end
    end
  end

  assign stall  = |(head_valid & ~pop);
  assign o_idle = ~|head_valid & ~|o_write_port_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_write_port_enable  <= '0;
      o_write_port_wen     <= '0;
      o_write_port_addr    <= '0;
      o_write_port_data_in <= '0;
      rr_ptr               <= '0;
      o_stall_count        <= '0;
      o_addr_error         <= 1'b0;
    end else begin
      o_write_port_enable  <= found;
      o_write_port_wen     <= nxt_wen;
      o_write_port_addr    <= nxt_addr;
      o_write_port_data_in <= nxt_data;
      for (int lb = 0; lb < NUM_LINE_BUFFERS; lb++) begin
        if (ARB_MODE == ARB_ROUND_ROBIN && found[lb])
          rr_ptr[lb] <= SW'((int'(winner[lb]) + 1) % NUM_SOURCES);
      end
      if (stall && o_stall_count != 16'hFFFF) o_stall_count <= o_stall_count + 16'd1;
      if (|err_pop) o_addr_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_activation_buffer_write_arbiter.sv
// Bench: fixed, round-robin and 3-line-buffer arbiters driven from per-source beat
// queues; a scoreboard matches every write port beat against expected writes.
module tb_activation_buffer_write_arbiter;
  import NVP_v1_constants::*;
  localparam int NS = 2, NL = 4, DW = 16, AW = 10;

  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  logic [NS-1:0][DW-1:0] data = '0;
  logic [NS-1:0][AW-1:0] address = '0;
  logic [2:0][NS-1:0]    valid = '0;

  logic [1:0][NS-1:0]          rdy;
  logic [1:0][NL-1:0]          en;
  logic [1:0][NL-1:0][3:0]     wen;
  logic [1:0][NL-1:0][5:0]     la;
  logic [1:0][NL-1:0][DW-1:0]  wd;
  logic [1:0][15:0]            stall;
  logic [1:0]                  err, idle;

  logic [NS-1:0]        rdy2;
  logic [2:0]           en2;
  logic [2:0][3:0]      wen2;
  logic [2:0][5:0]      la2;
  logic [2:0][DW-1:0]   wd2;
  logic [15:0]          stall2;
  logic                 err2, idle2;

  activation_buffer_write_arbiter u_fix (
    .clk(clk), .reset(reset), .i_src_valid(valid[0]), .o_src_ready(rdy[0]),
    .i_src_data(data), .i_src_address(address), .o_write_port_enable(en[0]),
    .o_write_port_wen(wen[0]), .o_write_port_addr(la[0]), .o_write_port_data_in(wd[0]),
    .o_stall_count(stall[0]), .o_addr_error(err[0]), .o_idle(idle[0]));

  activation_buffer_write_arbiter #(.ARB_MODE(ARB_ROUND_ROBIN)) u_rr (
    .clk(clk), .reset(reset), .i_src_valid(valid[1]), .o_src_ready(rdy[1]),
    .i_src_data(data), .i_src_address(address), .o_write_port_enable(en[1]),
    .o_write_port_wen(wen[1]), .o_write_port_addr(la[1]), .o_write_port_data_in(wd[1]),
    .o_stall_count(stall[1]), .o_addr_error(err[1]), .o_idle(idle[1]));

  activation_buffer_write_arbiter #(.NUM_LINE_BUFFERS(3)) u_lb3 (
    .clk(clk), .reset(reset), .i_src_valid(valid[2]), .o_src_ready(rdy2),
    .i_src_data(data), .i_src_address(address), .o_write_port_enable(en2),
    .o_write_port_wen(wen2), .o_write_port_addr(la2), .o_write_port_data_in(wd2),
    .o_stall_count(stall2), .o_addr_error(err2), .o_idle(idle2));

  typedef struct packed { logic [1:0] lb; logic [3:0] wen; logic [5:0] la; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } beat_t;
  typedef struct { int dut; int lb; int src; int cyc; } log_t;
  typedef struct { logic [1:0] v; logic [9:0] a0; logic [9:0] a1; int stl; bit same; } vec_t;

  beat_t tx_q [3][NS][$];
  wr_t   exp_q[2][NS][$];
  log_t  wlog[$];
  int    acc_cnt[3][NS];
  int    compared = 0, mismatched = 0, cyc = 0, seq = 0;
  vec_t  tbl[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic wr_t to_wr(beat_t b);
    wr_t w;
    logic [AW-1:0] a;
    a = b.a;
    w.lb  = a[9:8];
    w.la  = a[7:2];
    w.wen = 4'b0001 << a[1:0];
    w.d   = b.d;
    return w;
  endfunction

  function automatic logic dut_ready(int d, int s);
    if (d == 0) return rdy[0][s];
    if (d == 1) return rdy[1][s];
    return rdy2[s];
  endfunction

  task automatic q_raw(int d, int s, logic [AW-1:0] a, logic [DW-1:0] dd);
    beat_t b;
    b.a = a;
    b.d = dd;
    tx_q[d][s].push_back(b);
  endtask

  // payload MSB tags the source so the scoreboard can route each write
  task automatic q_beat(int d, int s, logic [AW-1:0] a);
    logic [DW-1:0] dd;
    seq++;
    dd = {s[0], 15'(seq)};
    q_raw(d, s, a, dd);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        for (int s = 0; s < NS; s++) begin
          valid[d][s] = (tx_q[d][s].size() > 0);
          if (valid[d][s]) begin
            data[s]    = tx_q[d][s][0].d;
            address[s] = tx_q[d][s][0].a;
          end
        end
      for (int d = 0; d < 3; d++)
        for (int s = 0; s < NS; s++)
          if (valid[d][s] && dut_ready(d, s)) begin
            if (d < 2) exp_q[d][s].push_back(to_wr(tx_q[d][s][0]));
            void'(tx_q[d][s].pop_front());
            acc_cnt[d][s]++;
          end
    end
    @(posedge clk);
    #1 valid = '0;
  endtask

  function automatic bit all_empty();
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < NS; s++) begin
        if (tx_q[d][s].size() != 0) return 0;
        if (d < 2 && exp_q[d][s].size() != 0) return 0;
      end
    return idle[0] && idle[1] && idle2;
  endfunction

  task automatic drain(int max);
    int i;
    for (i = 0; i < max && !all_empty(); i++) run(1);
    chk("drain_timeout", {63'd0, all_empty()}, 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++) begin
        int  s;
        wr_t got, e;
        if (en[d][l]) begin
          s   = int'(wd[d][l][DW-1]);
          got = {2'(l), wen[d][l], la[d][l], wd[d][l]};
          wlog.push_back('{d, l, s, cyc});
          if (exp_q[d][s].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write: dut %0d lb %0d got 0x%0h expected none", d, l, got);
          end else begin
            e = exp_q[d][s].pop_front();
            chk($sformatf("sb_write_d%0d_lb%0d", d, l), 64'(got), 64'(e));
          end
        end else
          chk($sformatf("idle_port_zero_d%0d_lb%0d", d, l), {wen[d][l], la[d][l], wd[d][l]}, 64'd0);
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0, c1, low_acc;
    bit saw_low;
    logic [2:0] en_or;

    tbl[0] = '{2'b01, 10'h2C5, 10'h000, 0, 0};
    tbl[1] = '{2'b11, 10'h100, 10'h104, 1, 0};
    tbl[2] = '{2'b11, 10'h000, 10'h300, 0, 1};
    tbl[3] = '{2'b10, 10'h000, 10'h3FC, 0, 0};
    tbl[4] = '{2'b11, 10'h201, 10'h203, 1, 0};
    tbl[5] = '{2'b01, 10'h0FF, 10'h000, 0, 0};
    tbl[6] = '{2'b11, 10'h1F0, 10'h2F0, 0, 1};
    for (int d = 0; d < 3; d++) for (int s = 0; s < NS; s++) acc_cnt[d][s] = 0;

    // reset state
    #1 reset = 1;
    #2;
    chk("rst_ready", {rdy, rdy2}, 64'd0);
    chk("rst_enable", {en, en2}, 64'd0);
    chk("rst_ports", {wen[0], la[0], wd[0][1:0]}, 64'd0);
    chk("rst_idle", {idle, idle2}, 64'h7);
    chk("rst_stall_err", {stall, err, err2}, 64'd0);
    @(negedge clk) reset = 0;
    @(posedge clk) #1;
    chk("rel_ready", {rdy, rdy2}, 64'h3F);

    // single beat timing and port contents
    q_raw(0, 0, 10'h2C5, 16'h00A5);
    run(1);
    @(posedge clk) #1;
    chk("single_en", en[0], 4'b0100);
    chk("single_wen", wen[0], 16'h0200);
    chk("single_addr", la[0], 24'd49 << 12);
    chk("single_data", wd[0], 64'h00A5 << 32);
    @(posedge clk) #1;
    chk("single_one_cycle", en[0], 4'b0000);
    drain(10);

    // table vectors on the fixed-priority arbiter
    foreach (tbl[i]) begin
      s0 = int'(stall[0]);
      wlog.delete();
      if (tbl[i].v[0]) q_beat(0, 0, tbl[i].a0);
      if (tbl[i].v[1]) q_beat(0, 1, tbl[i].a1);
      run(1);
      drain(20);
      chk($sformatf("vec%0d_stall", i), 64'(int'(stall[0]) - s0), 64'(tbl[i].stl));
      chk($sformatf("vec%0d_nwrites", i), 64'(wlog.size()), 64'($countones(tbl[i].v)));
      if (tbl[i].v == 2'b11 && wlog.size() == 2) begin
        c0 = (wlog[0].src == 0) ? wlog[0].cyc : wlog[1].cyc;
        c1 = (wlog[0].src == 1) ? wlog[0].cyc : wlog[1].cyc;
        chk($sformatf("vec%0d_cycle_gap", i), 64'(c1 - c0), tbl[i].same ? 64'd0 : 64'd1);
      end
    end

    // round robin: two 4-beat streams to lb 0 interleave back to back
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      q_beat(1, 0, {2'b00, 6'(i), 2'(i)});
      q_beat(1, 1, {2'b00, 6'(i + 8), 2'(i + 1)});
    end
    run(4);
    drain(30);
    chk("rr_nwrites", 64'(wlog.size()), 64'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk($sformatf("rr_src%0d", i), 64'(wlog[i].src), 64'(i % 2));
      if (i > 0) chk($sformatf("rr_back_to_back%0d", i), 64'(wlog[i].cyc - wlog[i-1].cyc), 64'd1);
    end

    // fixed priority starvation: src1 backs up to full and recovers losslessly
    for (int s = 0; s < NS; s++) acc_cnt[0][s] = 0;
    for (int i = 0; i < 10; i++) q_beat(0, 0, {2'b10, 6'(i), 2'b00});
    for (int i = 0; i < 6; i++)  q_beat(0, 1, {2'b10, 6'(i + 20), 2'b11});
    saw_low = 0;
    low_acc = -1;
    for (int i = 0; i < 9; i++) begin
      run(1);
      if (!saw_low && !rdy[0][1]) begin
        saw_low = 1;
        low_acc = acc_cnt[0][1];
      end
    end
    chk("starve_ready_fell", {63'd0, saw_low}, 64'd1);
    chk("starve_acc_at_full", 64'(low_acc), 64'd4);
    drain(40);
    chk("starve_src1_total", 64'(acc_cnt[0][1]), 64'd6);

    // out-of-range line-buffer select on the 3-buffer arbiter
    chk("err_clear", {63'd0, err2}, 64'd0);
    q_raw(2, 0, 10'h3FF, 16'h1234);
    q_raw(2, 0, 10'h004, 16'h0055);
    en_or = '0;
    run(2);
    for (int i = 0; i < 5; i++) begin
      en_or |= en2;
      @(posedge clk) #1;
    end
    chk("err_only_lb0_written", en_or, 3'b001);
    chk("err_sticky", {63'd0, err2}, 64'd1);
    chk("err_idle", {63'd0, idle2}, 64'd1);

    // reset mid-burst with three src1 beats stuck behind src0
    for (int i = 0; i < 20; i++) q_beat(0, 0, {2'b10, 6'(i), 2'b01});
    for (int i = 0; i < 3; i++)  q_beat(0, 1, {2'b10, 6'(i + 40), 2'b10});
    for (int s = 0; s < NS; s++) acc_cnt[0][s] = 0;
    run(4);
    chk("mid_src1_queued", 64'(acc_cnt[0][1]), 64'd3);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("mid_rst_ready", rdy[0], 2'b00);
    chk("mid_rst_ports", {en[0], wen[0], la[0][1:0]}, 64'd0);
    chk("mid_rst_data", wd[0], 64'd0);
    chk("mid_rst_idle", {63'd0, idle[0]}, 64'd1);
    chk("mid_rst_stall", {stall[0], err[0]}, 64'd0);
    for (int s = 0; s < NS; s++) begin
      tx_q[0][s].delete();
      exp_q[0][s].delete();
    end
    @(negedge clk) reset = 0;
    @(posedge clk) #1;
    chk("mid_rel_ready", rdy[0], 2'b11);
    run(6);
    chk("mid_post_idle", {63'd0, idle[0]}, 64'd1);

    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NS; s++)
        chk($sformatf("final_sb_empty_d%0d_s%0d", d, s), 64'(exp_q[d][s].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
